// File: rtl/digit_entry.sv
// rtl/digit_entry.sv - BCD guess entry: digits, backspace, enter; optional timeout via DIGIT_ENTRY_TIMEOUT_EN
// Outputs are registered; simultaneous keys resolve arm > key_back > key_valid > key_enter.
module digit_entry #(
  parameter int          NUM_DIGITS     = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic                    key_valid,
  input  logic [3:0]              key_digit,
  input  logic                    key_back,
  input  logic                    key_enter,
  output logic [4*NUM_DIGITS-1:0] user_int,
  output logic [2:0]              digit_count,
  output logic                    entry_active,
  output logic                    submit,
  output logic                    reject,
  output logic                    timed_out
);

  localparam int W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   user_nxt;
  logic [2:0]     count_nxt;
  logic           submit_nxt;
  logic           reject_nxt;
  logic           timeout_nxt;
  logic           accepted;
  logic           in_entry;
  logic           expire;

  assign in_entry = (state == ENTRY) || (state == FULL);

`ifdef DIGIT_ENTRY_TIMEOUT_EN
  logic [31:0] idle_cnt;

  assign expire = in_entry && (idle_cnt == TIMEOUT_CYCLES - 32'd1);

  // Only accepted keys restart the idle window; rejected keys do not.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= 32'd0;
    end else if (arm || accepted || expire || !in_entry) begin
      idle_cnt <= 32'd0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  localparam logic unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    user_nxt    = user_int;
    count_nxt   = digit_count;
    submit_nxt  = 1'b0;
    reject_nxt  = 1'b0;
    timeout_nxt = 1'b0;
    accepted    = 1'b0;

    if (arm) begin
      state_nxt = ENTRY;
      user_nxt  = '0;
      count_nxt = 3'd0;
    end else if (in_entry) begin
      if (expire) begin
        // Timeout wins over any key in the same cycle; the key is dropped.
        state_nxt   = DONE;
        timeout_nxt = 1'b1;
      end else if (key_back) begin
        if (digit_count != 3'd0) begin
          user_nxt  = user_int >> 4;
          count_nxt = digit_count - 3'd1;
          state_nxt = ENTRY;
          accepted  = 1'b1;
        end else begin
          reject_nxt = 1'b1;
        end
      end else if (key_valid) begin
        if ((state == FULL) || (key_digit > 4'd9)) begin
          reject_nxt = 1'b1;
        end else begin
          user_nxt  = {user_int[W-5:0], key_digit};
          count_nxt = digit_count + 3'd1;
          accepted  = 1'b1;
          if (count_nxt == 3'(NUM_DIGITS)) begin
            state_nxt = FULL;
          end
        end
      end else if (key_enter) begin
        if (state == FULL) begin
          state_nxt  = DONE;
          submit_nxt = 1'b1;
        end else begin
          reject_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      user_int     <= '0;
      digit_count  <= 3'd0;
      entry_active <= 1'b0;
      submit       <= 1'b0;
      reject       <= 1'b0;
      timed_out    <= 1'b0;
    end else begin
      state        <= state_nxt;
      user_int     <= user_nxt;
      digit_count  <= count_nxt;
      entry_active <= (state_nxt == ENTRY) || (state_nxt == FULL);
      submit       <= submit_nxt;
      reject       <= reject_nxt;
      timed_out    <= timeout_nxt;
    end
  end

endmodule
